// File: rtl/clause_table_multiport_pkg.sv
// Shared types and helpers for the multiport clause table.
package clause_pkg;

  // Operating modes; encoding is visible on state_o.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Width of one packed clause row: each clause keeps NSAT-1 partner literals,
  // each literal being a variable address plus a negation bit.
  function automatic int unsigned ct_width(input int unsigned clause_count,
                                           input int unsigned var_addr_width,
                                           input int unsigned nsat);
    return (var_addr_width + 1) * (nsat - 1) * clause_count;
  endfunction

endpackage

// File: rtl/clause_table_bank.sv
// One clause-table bank: simple dual-port memory with a shared write port
// and a private registered read port (BRAM-inferable, no reset on storage).
module clause_table_bank #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned WIDTH = 480,
  parameter int unsigned AW    = 11
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Write port: callers guarantee wr_addr_i < DEPTH whenever wr_en_i is set.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) r_mem[wr_addr_i] <= wr_data_i;
  end

  // Read port: register only on accepted reads so the data holds otherwise.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) r_rd_data <= r_mem[rd_addr_i];
  end

  assign rd_data_o = r_rd_data;

endmodule

// File: rtl/clause_table_multiport.sv
// Multiport clause store: CLEAR/LOAD/RUN mode FSM, hardware clear, AXI row
// loader and NUM_RD_PORTS independent pipelined read lanes (one bank per lane).
module clause_table_multiport
  import clause_pkg::*;
#(
  parameter int unsigned CLAUSE_COUNT   = 20,
  parameter int unsigned VAR_ADDR_WIDTH = 11,
  parameter int unsigned NSAT           = 3,
  parameter int unsigned DEPTH          = 2048,
  parameter int unsigned NUM_RD_PORTS   = 2,
  parameter int unsigned RD_LATENCY     = 1,
  localparam int unsigned CT_WIDTH      = ct_width(CLAUSE_COUNT, VAR_ADDR_WIDTH, NSAT),
  localparam int unsigned AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             clear_i,
  output logic [1:0]                       state_o,
  output logic                             busy_o,
  input  logic                             axi_wr_en_i,
  input  logic [AW-1:0]                    axi_wr_addr_i,
  input  logic [CT_WIDTH-1:0]              axi_wr_clauses_i,
  output logic                             wr_err_o,
  input  logic [NUM_RD_PORTS-1:0]          rd_valid_i,
  input  logic [NUM_RD_PORTS*AW-1:0]       rd_addr_i,
  output logic [NUM_RD_PORTS*CT_WIDTH-1:0] clauses_o,
  output logic [NUM_RD_PORTS-1:0]          rd_valid_o,
  output logic [NUM_RD_PORTS-1:0]          rd_err_o
);

  state_e                                     r_state;
  state_e                                     w_state_nxt;
  logic [AW-1:0]                              r_clr_cnt;
  logic                                       w_clr_last;

  logic                                       w_axi_ok;
  logic                                       w_we;
  logic [AW-1:0]                              w_waddr;
  logic [CT_WIDTH-1:0]                        w_wdata;
  logic                                       r_wr_err;

  logic [AW-1:0]                              w_rd_addr  [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0]                    w_rd_ok;
  logic [NUM_RD_PORTS-1:0]                    w_rd_drop;
  logic [RD_LATENCY-1:0][NUM_RD_PORTS-1:0]    r_vpipe;
  logic [RD_LATENCY-1:0][NUM_RD_PORTS-1:0]    r_epipe;
  logic [CT_WIDTH-1:0]                        w_bank_data [NUM_RD_PORTS];
  logic [CT_WIDTH-1:0]                        w_lane      [NUM_RD_PORTS];

  assign w_clr_last = (r_clr_cnt == AW'(DEPTH - 1));

  // Mode state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_CLEAR;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; clear_i overrides start_i.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_CLEAR: if (w_clr_last) w_state_nxt = ST_LOAD;
      ST_LOAD:  if (start_i)    w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_CLEAR;
    endcase
    if (clear_i) w_state_nxt = ST_CLEAR;
  end

  // Clear row counter: walks 0..DEPTH-1 while clearing, restarts on clear_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_clr_cnt <= '0;
    end else if (clear_i || r_state != ST_CLEAR || w_clr_last) begin
      r_clr_cnt <= '0;
    end else begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  // Shared write port: zero fill during CLEAR, otherwise accepted AXI writes.
  always_comb begin
    w_axi_ok = axi_wr_en_i && (r_state == ST_LOAD) && (32'(axi_wr_addr_i) < DEPTH);
    w_we     = w_axi_ok;
    w_waddr  = axi_wr_addr_i;
    w_wdata  = axi_wr_clauses_i;
    if (r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_cnt;
      w_wdata = '0;
    end
  end

  // Write-error pulse for dropped AXI writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_wr_err <= 1'b0;
    else       r_wr_err <= axi_wr_en_i && !w_axi_ok;
  end

  // Per-lane request decode: accept in RUN with an in-range address.
  always_comb begin
    w_rd_ok   = '0;
    w_rd_drop = '0;
    for (int unsigned k = 0; k < NUM_RD_PORTS; k++) begin
      w_rd_addr[k] = rd_addr_i[k*AW +: AW];
      if (rd_valid_i[k]) begin
        if (r_state == ST_RUN && 32'(w_rd_addr[k]) < DEPTH) w_rd_ok[k]   = 1'b1;
        else                                                w_rd_drop[k] = 1'b1;
      end
    end
  end

  // Valid/error pipelines aligned with the read data path.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vpipe <= '0;
      r_epipe <= '0;
    end else begin
      r_vpipe[0] <= w_rd_ok;
      r_epipe[0] <= w_rd_drop;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        r_epipe[i] <= r_epipe[i-1];
      end
    end
  end

  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_bank
    clause_table_bank #(
      .DEPTH (DEPTH),
      .WIDTH (CT_WIDTH),
      .AW    (AW)
    ) u_bank (
      .clk_i     (clk_i),
      .wr_en_i   (w_we),
      .wr_addr_i (w_waddr),
      .wr_data_i (w_wdata),
      .rd_en_i   (w_rd_ok[k]),
      .rd_addr_i (w_rd_addr[k]),
      .rd_data_o (w_bank_data[k])
    );
  end

  if (RD_LATENCY == 1) begin : g_lat1
    // The RAM register has no reset, so a per-lane zero mask provides the
    // reset value and the zeroing on a dropped read while keeping BRAM inference.
    logic [NUM_RD_PORTS-1:0] r_zero;

    // Zero mask: set by reset or a dropped read, released by an accepted read.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_zero <= '1;
      end else begin
        for (int unsigned k = 0; k < NUM_RD_PORTS; k++) begin
          if (w_rd_ok[k])        r_zero[k] <= 1'b0;
          else if (w_rd_drop[k]) r_zero[k] <= 1'b1;
        end
      end
    end

    // Lane data straight from the bank register, masked to zero when required.
    always_comb begin
      for (int unsigned k = 0; k < NUM_RD_PORTS; k++) begin
        w_lane[k] = r_zero[k] ? '0 : w_bank_data[k];
      end
    end
  end else begin : g_lat2
    logic [CT_WIDTH-1:0] r_out [NUM_RD_PORTS];

    // Output register stage: load on valid, zero on drop, hold otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int unsigned k = 0; k < NUM_RD_PORTS; k++) r_out[k] <= '0;
      end else begin
        for (int unsigned k = 0; k < NUM_RD_PORTS; k++) begin
          if (r_vpipe[0][k])      r_out[k] <= w_bank_data[k];
          else if (r_epipe[0][k]) r_out[k] <= '0;
        end
      end
    end

    // Lane data from the output register stage.
    always_comb begin
      for (int unsigned k = 0; k < NUM_RD_PORTS; k++) w_lane[k] = r_out[k];
    end
  end

  // Pack lane data onto the flat output bus.
  always_comb begin
    clauses_o = '0;
    for (int unsigned k = 0; k < NUM_RD_PORTS; k++) begin
      clauses_o[k*CT_WIDTH +: CT_WIDTH] = w_lane[k];
    end
  end

  assign state_o    = r_state;
  assign busy_o     = (r_state == ST_CLEAR);
  assign wr_err_o   = r_wr_err;
  assign rd_valid_o = r_vpipe[RD_LATENCY-1];
  assign rd_err_o   = r_epipe[RD_LATENCY-1];

endmodule

// File: tb/tb_clause_table_multiport.sv
// Scoreboard bench for clause_table_multiport: one instance with DEPTH=2048,
// RD_LATENCY=1 and one with DEPTH=1000, RD_LATENCY=2, driven by the same
// directed sequence. Read expectations are queued per lane at issue time and
// popped by a per-instance monitor when they fall due.
module tb_clause_table_multiport;
  import clause_pkg::*;

  localparam int unsigned CT = ct_width(20, 11, 3);
  localparam int unsigned NP = 2;

  typedef struct {
    bit               err;
    logic [CT-1:0]    data;
    int unsigned      due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [CT-1:0] fill(input logic [7:0] b);
    logic [CT-1:0] r;
    for (int i = 0; i < int'(CT / 8); i++) r[i*8 +: 8] = b;
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u_inst
    localparam int unsigned DEP = (g == 0) ? 2048 : 1000;
    localparam int unsigned LAT = (g == 0) ? 1 : 2;
    localparam int unsigned AW  = $clog2(DEP);

    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              clear = 1'b0;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [CT-1:0]     wr_data = '0;
    logic [1:0]        state;
    logic              busy;
    logic              wr_err;
    logic [NP-1:0]     rdv_i = '0;
    logic [NP*AW-1:0]  rda_i = '0;
    logic [NP*CT-1:0]  cl_o;
    logic [NP-1:0]     rdv_o;
    logic [NP-1:0]     rde_o;

    clause_table_multiport #(
      .CLAUSE_COUNT   (20),
      .VAR_ADDR_WIDTH (11),
      .NSAT           (3),
      .DEPTH          (DEP),
      .NUM_RD_PORTS   (NP),
      .RD_LATENCY     (LAT)
    ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .start_i          (start),
      .clear_i          (clear),
      .state_o          (state),
      .busy_o           (busy),
      .axi_wr_en_i      (wr_en),
      .axi_wr_addr_i    (wr_addr),
      .axi_wr_clauses_i (wr_data),
      .wr_err_o         (wr_err),
      .rd_valid_i       (rdv_i),
      .rd_addr_i        (rda_i),
      .clauses_o        (cl_o),
      .rd_valid_o       (rdv_o),
      .rd_err_o         (rde_o)
    );

    exp_t          q [NP][$];
    logic [CT-1:0] mem [int];
    logic [CT-1:0] last [NP];
    int unsigned   cyc = 0;
    state_e        m_state = ST_CLEAR;
    bit            done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop due expectations, otherwise require idle lanes holding data.
    always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst) begin
        for (int k = 0; k < int'(NP); k++) last[k] = '0;
      end else begin
        for (int k = 0; k < int'(NP); k++) begin
          if (q[k].size() > 0 && q[k][0].due == cyc) begin
            e = q[k].pop_front();
            checks++;
            if (rdv_o[k] !== ~e.err || rde_o[k] !== e.err || cl_o[k*CT +: CT] !== e.data) begin
              errors++;
              $display("FAIL inst%0d lane%0d read@%0d: got v=%0b e=%0b d=%h required v=%0b e=%0b d=%h",
                       g, k, cyc, rdv_o[k], rde_o[k], cl_o[k*CT +: CT], ~e.err, e.err, e.data);
            end
            last[k] = e.data;
          end else begin
            checks++;
            if (rdv_o[k] !== 1'b0 || rde_o[k] !== 1'b0 || cl_o[k*CT +: CT] !== last[k]) begin
              errors++;
              $display("FAIL inst%0d lane%0d idle/hold@%0d: got v=%0b e=%0b d=%h required v=0 e=0 d=%h",
                       g, k, cyc, rdv_o[k], rde_o[k], cl_o[k*CT +: CT], last[k]);
            end
          end
        end
      end
    end

    function automatic logic [CT-1:0] mget(input int a);
      return mem.exists(a) ? mem[a] : '0;
    endfunction

    task automatic chk(input string name, input logic [CT-1:0] got, input logic [CT-1:0] exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL inst%0d %s: got %0h required %0h", g, name, got, exp);
      end
    endtask

    // Issue one cycle of reads on both lanes; starts and ends on a negedge.
    task automatic rd(input bit v0, input int a0, input bit v1, input int a1);
      bit   v [NP];
      int   a [NP];
      exp_t e;
      v[0] = v0; v[1] = v1; a[0] = a0; a[1] = a1;
      for (int k = 0; k < int'(NP); k++) begin
        if (v[k]) begin
          e.err  = !(m_state == ST_RUN && a[k] < int'(DEP));
          e.data = e.err ? '0 : mget(a[k]);
          e.due  = cyc + LAT;
          q[k].push_back(e);
        end
      end
      rdv_i = {v1, v0};
      rda_i = {AW'(a1), AW'(a0)};
      @(negedge clk);
      rdv_i = '0;
    endtask

    task automatic wr(input int a, input logic [CT-1:0] d, input bit with_start);
      bit ok;
      ok      = (m_state == ST_LOAD) && a < int'(DEP);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      start   = with_start;
      @(posedge clk); #1;
      if (ok) mem[a] = d;
      if (with_start && m_state == ST_LOAD) m_state = ST_RUN;
      chk("wr_err", wr_err, !ok);
      if (with_start) chk("state after start+write", state, m_state);
      @(negedge clk);
      wr_en = 1'b0;
      start = 1'b0;
    endtask

    task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      if (m_state == ST_LOAD) m_state = ST_RUN;
      chk("state after start", state, m_state);
      @(negedge clk);
      start = 1'b0;
    endtask

    task automatic do_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      m_state = ST_CLEAR;
      mem.delete();
      chk("state after clear", state, ST_CLEAR);
      chk("busy after clear", busy, 1'b1);
      @(negedge clk);
      clear = 1'b0;
    endtask

    // Count edges until LOAD appears; called on the negedge after the trigger.
    task automatic count_clear(input string name);
      int n;
      int nbusy;
      n = 0;
      nbusy = 0;
      while (n < int'(4 * DEP)) begin
        @(posedge clk); #1;
        n++;
        if (state == ST_LOAD) break;
        if (busy === 1'b1) nbusy++;
      end
      chk({name, " cycles"}, n, DEP);
      chk({name, " busy cycles"}, nbusy, DEP - 1);
      chk({name, " busy low in LOAD"}, busy, 1'b0);
      m_state = ST_LOAD;
      @(negedge clk);
    endtask

    initial begin
      int oob;
      int rows [4];
      oob  = int'(DEP % (1 << AW));
      rows = '{7, int'(DEP) - 1, 9, 5};
      repeat (2) @(negedge clk);
      chk("reset state", state, ST_CLEAR);
      chk("reset busy", busy, 1'b1);
      chk("reset wr_err", wr_err, 1'b0);
      chk("reset rd_valid", rdv_o, '0);
      chk("reset rd_err", rde_o, '0);
      chk("reset lane0", cl_o[0 +: CT], '0);
      chk("reset lane1", cl_o[CT +: CT], '0);
      rst = 1'b0;
      count_clear("initial clear");

      rd(1'b1, 7, 1'b1, 5);
      wr(7, fill(8'hA5), 1'b0);
      wr(int'(DEP) - 1, fill(8'h3C), 1'b0);
      wr(oob, fill(8'h5A), 1'b0);
      wr(9, fill(8'h0F), 1'b1);

      rd(1'b1, 5, 1'b1, 5);
      rd(1'b1, 7, 1'b1, int'(DEP) - 1);
      rd(1'b1, 9, 1'b1, oob);
      wr(7, fill(8'hFF), 1'b0);
      do_start();
      rd(1'b1, 7, 1'b1, 7);
      for (int i = 0; i < 16; i++) rd(1'b1, rows[i % 4], 1'b1, rows[i % 4]);
      rd(1'b0, 0, 1'b0, 0);
      rd(1'b1, oob, 1'b0, 0);
      rd(1'b0, 0, 1'b0, 0);

      rd(1'b1, 7, 1'b1, 9);
      rd(1'b1, int'(DEP) - 1, 1'b1, 7);
      do_clear();
      count_clear("run clear");

      do_clear();
      repeat (300) @(negedge clk);
      do_start();
      do_clear();
      repeat (200) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_state = ST_CLEAR;
      count_clear("clear after reset");

      do_start();
      rd(1'b1, 7, 1'b1, int'(DEP) - 1);
      repeat (LAT + 2) @(negedge clk);
      chk("scoreboard drained", q[0].size() + q[1].size(), 0);
      done = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (t < 50000 && !(u_inst[0].done && u_inst[1].done)) begin
      @(negedge clk);
      t++;
    end
    if (!(u_inst[0].done && u_inst[1].done)) begin
      checks++;
      errors++;
      $display("FAIL timeout: sequences done=%0b%0b required 11", u_inst[1].done, u_inst[0].done);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
